axi_sram_slave: RTL
===================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 ADDR_WIDTH, 16, word-index bits of the backing array (2^ADDR_WIDTH 32-bit words).
REQ-002 WAIT_CYCLES, 4, extra idle cycles before first R beat (used only with AXI_SLV_WAIT_EN).
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 arid  input  4  read transaction ID.
REQ-006 araddr  input  32  read byte address; bits [1:0] ignored.
REQ-007 arlen  input  4  read beats minus one.
REQ-008 arvalid  input  1  AR request valid.
REQ-009 arready  output  1  AR accept.
REQ-010 rid  output  4  echoed read ID.
REQ-011 rdata  output  32  read beat data.
REQ-012 rresp  output  2  read response, always 2'b00.
REQ-013 rlast  output  1  final read beat.
REQ-014 rvalid  output  1  R beat valid.
REQ-015 rready  input  1  master accepts R beat.
REQ-016 awid  input  4  write transaction ID.
REQ-017 awaddr  input  32  write byte address; bits [1:0] ignored.
REQ-018 awlen  input  4  write beats minus one.
REQ-019 awvalid  input  1  AW request valid.
REQ-020 awready  output  1  AW accept.
REQ-021 wdata  input  32  write beat data.
REQ-022 wstrb  input  4  byte enables, bit i -> wdata[8i+7:8i].
REQ-023 wlast  input  1  final write beat.
REQ-024 wvalid  input  1  W beat valid.
REQ-025 wready  output  1  W accept.
REQ-026 bid  output  4  echoed write ID.
REQ-027 bresp  output  2  write response.
REQ-028 bvalid  output  1  B valid.
REQ-029 bready  input  1  master accepts B.

Function
REQ-030 Bursts SHALL be INCR, 4 bytes/beat; size/burst/lock/cache/prot not ported; word index = addr[ADDR_WIDTH+1:2], incremented per beat modulo 2^ADDR_WIDTH (wrap at top of array).
REQ-031 Read FSM SHALL be R_IDLE -> R_DATA -> R_IDLE; arready=1 only in R_IDLE; AR handshake latches arid, word index, beat count = arlen.
REQ-032 In R_DATA rvalid=1, rdata=mem[index] (combinational array read), rlast=(count==0); on rvalid&rready: count==0 -> R_IDLE, else index+1, count-1; rvalid/rdata/rid held stable while rready=0.
REQ-033 First rvalid SHALL assert the cycle after the AR handshake; one beat per cycle when rready stays high.
REQ-034 Write FSM SHALL be W_IDLE -> W_DATA -> W_RESP -> W_IDLE; awready=1 only in W_IDLE; wready=1 only in W_DATA; bvalid=1 only in W_RESP.
REQ-035 On wvalid&wready, bytes with wstrb=1 written at posedge, index+1, count-1; leave W_DATA on wlast or count==0.
REQ-036 bresp=2'b00 if wlast coincided with count==0, else 2'b10 (SLVERR) for early or missing wlast; W_RESP -> W_IDLE on bready; bid = latched awid.
REQ-037 Read and write FSMs independent and concurrent; same-word read and write in one cycle returns pre-write data.
REQ-038 Outstanding depth 1 per channel; no AR/AW accepted until current burst (including B) completes.

Reset
REQ-039 rst high at posedge: both FSMs to IDLE, arready=1, awready=1, rvalid=0, rlast=0, wready=0, bvalid=0, rid=0, bid=0, bresp=0, rdata=0; in-flight bursts abandoned, no further beats.
REQ-040 Memory array contents SHALL NOT be affected by rst.

Configuration
REQ-041 Macro AXI_SLV_WAIT_EN defined: read FSM gains R_WAIT between R_IDLE and R_DATA, holding WAIT_CYCLES cycles (first rvalid WAIT_CYCLES+1 cycles after AR); undefined: no R_WAIT, REQ-033 timing.

Verification
REQ-042 AW 0x100 awlen=3, 4 W beats 0xA0..0xA3 strb=F, last on 4th -> bvalid, bresp=00, bid=awid; AR 0x100 arlen=3 -> rdata A0..A3, rlast on beat 4 only.
REQ-043 Write 0x11223344 strb=4'b0101 over 0xFFFFFFFF -> readback 0xFF22FF44.
REQ-044 AR at last word, arlen=1 -> beat 2 reads word index 0 (wrap).
REQ-045 awlen=3 with wlast on beat 2 -> bresp=2'b10, word 3 untouched; rready low 3 cycles mid-burst -> rdata/rlast stable.
REQ-046 rst asserted mid read burst -> next cycle rvalid=0, arready=1; with AXI_SLV_WAIT_EN, WAIT_CYCLES=4 -> first rvalid 5 cycles after AR.

Source files
------------

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI INCR-burst SRAM slave with independent read/write FSMs
// Optional read wait states: define AXI_SLV_WAIT_EN to insert WAIT_CYCLES idle cycles before the first R beat.
module axi_sram_slave #(
    parameter int ADDR_WIDTH  = 16,
    parameter int WAIT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    typedef logic [ADDR_WIDTH-1:0] idx_t;
    localparam idx_t IDX_ONE = idx_t'(1);

    typedef enum logic [1:0] { R_IDLE, R_WAIT, R_DATA } r_state_t;
    typedef enum logic [1:0] { W_IDLE, W_DATA, W_RESP } w_state_t;

    logic [31:0] mem_q [DEPTH];

    r_state_t   r_state_q, r_state_d;
    idx_t       r_idx_q, r_idx_d;
    logic [3:0] r_cnt_q, r_cnt_d;
    logic [3:0] rid_q, rid_d;

    w_state_t   w_state_q, w_state_d;
    idx_t       w_idx_q, w_idx_d;
    logic [3:0] w_cnt_q, w_cnt_d;
    logic [3:0] bid_q, bid_d;
    logic [1:0] bresp_q, bresp_d;
    logic       w_beat;

`ifdef AXI_SLV_WAIT_EN
    localparam int WC_W = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

    // Only the word-index slice of each address reaches the array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{araddr[31:ADDR_WIDTH+2], araddr[1:0],
                                awaddr[31:ADDR_WIDTH+2], awaddr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= R_IDLE;
            r_idx_q    <= '0;
            r_cnt_q    <= '0;
            rid_q      <= '0;
`ifdef AXI_SLV_WAIT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            r_state_q  <= r_state_d;
            r_idx_q    <= r_idx_d;
            r_cnt_q    <= r_cnt_d;
            rid_q      <= rid_d;
`ifdef AXI_SLV_WAIT_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_cnt_d   = r_cnt_q;
        rid_d     = rid_q;
`ifdef AXI_SLV_WAIT_EN
        wait_cnt_d = wait_cnt_q;
`endif
        case (r_state_q)
            R_IDLE: begin
                if (arvalid) begin
                    rid_d   = arid;
                    r_idx_d = araddr[ADDR_WIDTH+1:2];
                    r_cnt_d = arlen;
`ifdef AXI_SLV_WAIT_EN
                    if (WAIT_CYCLES > 0) begin
                        r_state_d  = R_WAIT;
                        wait_cnt_d = WC_W'(WAIT_CYCLES - 1);
                    end else begin
                        r_state_d = R_DATA;
                    end
`else
                    r_state_d = R_DATA;
`endif
                end
            end
            R_WAIT: begin
`ifdef AXI_SLV_WAIT_EN
                if (wait_cnt_q == '0) begin
                    r_state_d = R_DATA;
                end else begin
                    wait_cnt_d = wait_cnt_q - WC_W'(1);
                end
`else
                r_state_d = R_IDLE;
`endif
            end
            R_DATA: begin
                if (rready) begin
                    if (r_cnt_q == 4'd0) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_idx_d = r_idx_q + IDX_ONE;
                        r_cnt_d = r_cnt_q - 4'd1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // The array read is combinational, so a same-cycle write is seen only on the next beat.
    always_comb begin
        arready = (r_state_q == R_IDLE);
        rvalid  = (r_state_q == R_DATA);
        rlast   = rvalid && (r_cnt_q == 4'd0);
        rdata   = rvalid ? mem_q[r_idx_q] : 32'd0;
        rid     = rid_q;
        rresp   = 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            w_idx_q   <= '0;
            w_cnt_q   <= '0;
            bid_q     <= '0;
            bresp_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            w_cnt_q   <= w_cnt_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_cnt_d   = w_cnt_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (awvalid) begin
                    bid_d     = awid;
                    w_idx_d   = awaddr[ADDR_WIDTH+1:2];
                    w_cnt_d   = awlen;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid) begin
                    w_idx_d = w_idx_q + IDX_ONE;
                    w_cnt_d = w_cnt_q - 4'd1;
                    // An early or missing wlast still closes the burst, flagged as SLVERR.
                    if (wlast || (w_cnt_q == 4'd0)) begin
                        w_state_d = W_RESP;
                        bresp_d   = (wlast && (w_cnt_q == 4'd0)) ? 2'b00 : 2'b10;
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        awready = (w_state_q == W_IDLE);
        wready  = (w_state_q == W_DATA);
        bvalid  = (w_state_q == W_RESP);
        bid     = bid_q;
        bresp   = bresp_q;
        w_beat  = wready && wvalid;
    end

    // Array has no reset; a beat coinciding with rst is dropped along with its burst.
    always_ff @(posedge clk) begin
        if (!rst && w_beat) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem_q[w_idx_q][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end
endmodule
